// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the data side.
// Each access runs as little-endian byte beats and ends with a one-cycle ready pulse.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]        mem_n;
  logic              grant_if;

  // Data side always wins; a flush in the same cycle only blocks the fetch.
  assign grant_if = !mem_req && if_req && !if_flush;

  always_comb begin
    case (mem_len)
      2'b00:   mem_n = 3'd1;
      2'b01:   mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req)       state_d = mem_we ? MEM_WR : MEM_RD;
        else if (grant_if) state_d = IF_RD;
      end
      IF_RD: begin
        if (if_flush)        state_d = IDLE;
        else if (k_q == n_q) state_d = DONE;
      end
      MEM_RD, MEM_WR: if (k_q == n_q) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    n_d         = n_q;
    k_d         = k_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req || grant_if) begin
          addr_d   = mem_req ? mem_addr : if_addr;
          n_d      = mem_req ? mem_n : 3'd4;
          wdata_d  = mem_wdata;
          result_d = '0;
          k_d      = 3'd1;
          ram_a_d  = addr_d;
          if (mem_req && mem_we) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end
        end
      end
      IF_RD, MEM_RD: begin
        // A flushed fetch leaves ram_a where it was and drops the partial word.
        if (!(state_q == IF_RD && if_flush)) begin
          for (int b = 0; b < NB; b++)
            if (k_q == 3'(b + 1)) result_d[8*b +: 8] = ram_din;
          if (k_q < n_q) begin
            ram_a_d = addr_q + ADDR_W'(k_q);
            k_d     = k_q + 3'd1;
          end else if (state_q == IF_RD) begin
            if_ready_d = 1'b1;
            if_data_d  = result_d;
          end else begin
            mem_ready_d = 1'b1;
            mem_rdata_d = result_d;
          end
        end
      end
      MEM_WR: begin
        if (k_q < n_q) begin
          ram_a_d  = addr_q + ADDR_W'(k_q);
          ram_wr_d = 1'b1;
          k_d      = k_q + 3'd1;
          for (int b = 0; b < NB; b++)
            if (k_q == 3'(b)) ram_dout_d = wdata_q[8*b +: 8];
        end else begin
          mem_ready_d = 1'b1;
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_ready  = if_ready_q;
  assign if_data   = if_data_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed RAM model, table of accesses, hand-written
// corner sequences and randomized traffic checked against a byte-array reference.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_ready;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  // RAM that the DUT drives; the low 16 address bits select the byte.
  bit [7:0]    ram [65536];
  logic [39:0] wr_log [$];
  assign ram_din = ram[ram_a[15:0]];
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_a[15:0]] <= ram_dout;
      wr_log.push_back({ram_a, ram_dout});
    end
  end

  // Reference memory, updated only from the spec's store rule.
  bit [7:0] model_mem [65536];
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int n_of(input bit is_mem, input logic [1:0] len);
    if (!is_mem) return 4;
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] w;
    logic [31:0] a;
    w = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      w[8*i +: 8] = model_mem[a[15:0]];
    end
    return w;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      model_mem[a[15:0]] = wd[8*i +: 8];
    end
  endtask

  // Issues one request, checks beat addresses, latency, pulse width and store bytes.
  task automatic run_access(input string tag, input bit is_mem, input bit we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] data);
    int n;
    int log0;
    int lat;
    logic [31:0] a;
    logic [39:0] e;
    n = n_of(is_mem, len);
    log0 = wr_log.size();
    lat = 0;
    data = '0;
    if (is_mem) begin
      mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= n) begin
        a = addr + 32'(c - 1);
        chk({tag, " ram_a"}, 64'(ram_a), 64'(a));
        chk({tag, " ram_wr"}, 64'(ram_wr), 64'(is_mem && we));
        if (is_mem && we) chk({tag, " ram_dout"}, 64'(ram_dout), 64'(wd[8*(c-1) +: 8]));
      end
      if (is_mem ? mem_ready : if_ready) begin
        lat = c;
        data = is_mem ? mem_rdata : if_data;
        break;
      end
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(n + 1));
    chk({tag, " wr at ready"}, 64'(ram_wr), 64'(0));
    tick();
    chk({tag, " pulse"}, 64'({if_ready, mem_ready}), 64'(0));
    if (is_mem && we) begin
      chk({tag, " nwrites"}, 64'(wr_log.size() - log0), 64'(n));
      for (int i = 0; i < n && log0 + i < wr_log.size(); i++) begin
        e = {addr + 32'(i), wd[8*i +: 8]};
        chk({tag, " wbeat"}, 64'(wr_log[log0 + i]), 64'(e));
      end
    end
  endtask

  initial begin
    logic [31:0] data;
    int          lat;
    int          cnt;
    int          log0;
    bit          r_mem;
    bit          r_we;
    logic [1:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wd;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
    tick(); tick(); tick();
    chk("reset ram_wr", 64'(ram_wr), 64'(0));
    chk("reset ram_a", 64'(ram_a), 64'(0));
    chk("reset ram_dout", 64'(ram_dout), 64'(0));
    chk("reset readies", 64'({if_ready, mem_ready}), 64'(0));
    chk("reset if_data", 64'(if_data), 64'(0));
    chk("reset mem_rdata", 64'(mem_rdata), 64'(0));
    rst = 1'b0;
    tick();

    vecs[0] = '{"st_1000",   1'b1, 1'b1, 2'b10, 32'h0000_1000, 32'h0000_0513, 32'h0};
    vecs[1] = '{"fetch_1000",1'b0, 1'b0, 2'b00, 32'h0000_1000, 32'h0,         32'h0000_0513};
    vecs[2] = '{"st_b20",    1'b1, 1'b1, 2'b00, 32'h0000_0020, 32'hDEAD_BEFF, 32'h0};
    vecs[3] = '{"ld_b20",    1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0,         32'h0000_00FF};
    vecs[4] = '{"ld_w20",    1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'h0000_00FF};
    vecs[5] = '{"st_wrap",   1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hABCD_1234, 32'h0};
    vecs[6] = '{"ld_wrap_h", 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_1234};
    vecs[7] = '{"ld_wrap_b", 1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h0000_0012};
    vecs[8] = '{"ld_h1001",  1'b1, 1'b0, 2'b01, 32'h0000_1001, 32'h0,         32'h0000_0005};
    vecs[9] = '{"st_2000",   1'b1, 1'b1, 2'b11, 32'h0000_2000, 32'h0000_006F, 32'h0};

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i].tag, vecs[i].is_mem, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, data);
      if (vecs[i].is_mem && vecs[i].we)
        model_store(vecs[i].addr, vecs[i].wdata, n_of(1'b1, vecs[i].len));
      else
        chk({vecs[i].tag, " data"}, 64'(data), 64'(vecs[i].exp));
      $display("vec %0d %s data=%h", i, vecs[i].tag, data);
    end

    // Simultaneous requests: data first, fetch granted only after DONE.
    mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
    if_addr = 32'h1000; if_req = 1'b1;
    tick();
    chk("pri E0 readies", 64'({if_ready, mem_ready}), 64'(0));
    tick();
    chk("pri mem_ready", 64'(mem_ready), 64'(1));
    chk("pri mem_rdata", 64'(mem_rdata), 64'(32'hFF));
    chk("pri if_ready", 64'(if_ready), 64'(0));
    mem_req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (if_ready) begin lat = c; break; end
    end
    if_req = 1'b0;
    chk("pri fetch edges", 64'(lat), 64'(6));
    chk("pri if_data", 64'(if_data), 64'(32'h0000_0513));
    tick();
    chk("pri pulse", 64'(if_ready), 64'(0));
    $display("seq priority fetch_edges=%0d if_data=%h", lat, if_data);

    // Flush during the second fetch beat.
    if_addr = 32'h1000; if_req = 1'b1;
    tick();
    chk("flush ram_a0", 64'(ram_a), 64'(32'h1000));
    tick();
    chk("flush ram_a1", 64'(ram_a), 64'(32'h1001));
    if_flush = 1'b1; if_req = 1'b0;
    cnt = 0;
    tick();
    chk("flush ram_a held", 64'(ram_a), 64'(32'h1001));
    if (if_ready) cnt++;
    if_flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (if_ready) cnt++;
    end
    chk("flush no if_ready", 64'(cnt), 64'(0));
    chk("flush ram_a idle", 64'(ram_a), 64'(32'h1001));
    run_access("fetch_2000", 1'b0, 1'b0, 2'b00, 32'h2000, 32'h0, data);
    chk("fetch_2000 data", 64'(data), 64'(32'h0000_006F));
    $display("seq flush ready_count=%0d refetch=%h", cnt, data);

    // Reset in the middle of a word store.
    log0 = wr_log.size();
    mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h1122_3344; mem_req = 1'b1;
    tick();
    tick();
    rst = 1'b1; mem_req = 1'b0;
    tick();
    chk("rst ram_wr", 64'(ram_wr), 64'(0));
    chk("rst readies", 64'({if_ready, mem_ready}), 64'(0));
    chk("rst ram_a", 64'(ram_a), 64'(0));
    chk("rst ram_dout", 64'(ram_dout), 64'(0));
    chk("rst if_data", 64'(if_data), 64'(0));
    chk("rst mem_rdata", 64'(mem_rdata), 64'(0));
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_ready || ram_wr) cnt++;
    end
    chk("rst no activity", 64'(cnt), 64'(0));
    chk("rst write count", 64'(wr_log.size() - log0), 64'(2));
    model_store(32'h300, 32'h1122_3344, 2);
    run_access("ld_300", 1'b1, 1'b0, 2'b10, 32'h300, 32'h0, data);
    chk("ld_300 data", 64'(data), 64'(model_load(32'h300, 4)));
    $display("seq reset writes=%0d readback=%h", wr_log.size() - log0, data);

    // Held back-to-back byte loads: a grant every third edge.
    mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20; mem_req = 1'b1;
    cnt = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("b2b ready pattern", 64'(mem_ready), 64'(t % 3 == 2));
      if (mem_ready) begin
        cnt++;
        chk("b2b rdata", 64'(mem_rdata), 64'(32'hFF));
      end
    end
    mem_req = 1'b0;
    tick();
    chk("b2b tail", 64'(mem_ready), 64'(0));
    $display("seq back_to_back pulses=%0d", cnt);

    // Randomized traffic against the byte-array reference.
    for (int t = 0; t < 60; t++) begin
      r_mem = ($urandom_range(0, 3) != 0);
      r_we  = r_mem && ($urandom_range(0, 1) == 1);
      r_len = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                           : 32'h0000_4000 + 32'($urandom_range(0, 31));
      r_wd = $urandom;
      run_access("rand", r_mem, r_we, r_len, r_addr, r_wd, data);
      if (r_we)
        model_store(r_addr, r_wd, n_of(r_mem, r_len));
      else
        chk("rand data", 64'(data), 64'(model_load(r_addr, n_of(r_mem, r_len))));
      $display("rand %0d mem=%0d we=%0d len=%0d addr=%h data=%h", t, r_mem, r_we, r_len, r_addr, data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
